// File: rtl/atomic_counter_reader.sv
// atomic_counter_reader: initiator that reads a 64-bit event counter as two
// 32-bit accesses over a req/ack link. The first access is flagged atomic so
// the responder freezes the high word for the second access. The assembled
// snapshot and its delta from the previous good snapshot go to a consumer.
//
// Consumer handshake: valid_o rises with value_o/delta_o and both hold stable
// until ready_i is sampled high on a rising edge while valid_o=1; that edge
// is the single transfer, and valid_o drops on the same edge.
module atomic_counter_reader #(
  parameter int ACK_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  output logic        req_o,
  output logic        atomic_o,
  input  logic        ack_i,
  input  logic [31:0] count_i,
  output logic [63:0] value_o,
  output logic [63:0] delta_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        busy_o,
  output logic        err_o,
  output logic        spurious_o,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] REQ_LO  = 3'd1;
  localparam logic [2:0] WAIT_LO = 3'd2;
  localparam logic [2:0] REQ_HI  = 3'd3;
  localparam logic [2:0] WAIT_HI = 3'd4;
  localparam logic [2:0] OUT     = 3'd5;

  // Last wait-cycle count before the link is declared dead.
  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  logic [2:0]  state_q;
  logic [2:0]  state_nxt;
  logic [7:0]  tmo_q;
  logic [31:0] lo_q;
  logic [63:0] prev_q;
  logic        timeout;
  logic        in_wait;
  logic        stray_ack;

  assign in_wait   = (state_q == WAIT_LO) || (state_q == WAIT_HI);
  // An ack outside a wait state has no request behind it.
  assign stray_ack = ack_i && !in_wait;

  // Request strobes decode straight from the state register, so they are
  // single-cycle by construction and atomic_o is never high without req_o.
  assign req_o     = (state_q == REQ_LO) || (state_q == REQ_HI);
  assign atomic_o  = (state_q == REQ_LO);
  assign dbg_state = state_q;

  // Next-state logic and timeout detection.
  always_comb begin
    state_nxt = state_q;
    timeout   = 1'b0;
    case (state_q)
      IDLE:    if (start_i) state_nxt = REQ_LO;
      REQ_LO:  state_nxt = WAIT_LO;
      WAIT_LO: begin
        if (ack_i) begin
          state_nxt = REQ_HI;
        end else if (tmo_q == TMO_LAST) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      REQ_HI:  state_nxt = WAIT_HI;
      WAIT_HI: begin
        if (ack_i) begin
          state_nxt = OUT;
        end else if (tmo_q == TMO_LAST) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      OUT:     if (ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus registered status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      busy_o     <= 1'b0;
      err_o      <= 1'b0;
      valid_o    <= 1'b0;
      spurious_o <= 1'b0;
    end else begin
      state_q <= state_nxt;
      busy_o  <= (state_nxt != IDLE);
      err_o   <= timeout;
      valid_o <= (state_nxt == OUT);
      if (stray_ack) spurious_o <= 1'b1;
    end
  end

  // Ack timeout counter: restarted by each request pulse, counts idle wait cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_q <= 8'd0;
    end else if (req_o) begin
      tmo_q <= 8'd0;
    end else if (in_wait && !ack_i) begin
      tmo_q <= tmo_q + 8'd1;
    end
  end

  // Data path: low-word capture, snapshot assembly and delta against prev.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lo_q    <= 32'd0;
      prev_q  <= 64'd0;
      value_o <= 64'd0;
      delta_o <= 64'd0;
    end else begin
      if (state_q == WAIT_LO && ack_i) lo_q <= count_i;
      if (state_q == WAIT_HI && ack_i) begin
        value_o <= {count_i, lo_q};
        delta_o <= {count_i, lo_q} - prev_q;
        prev_q  <= {count_i, lo_q};
      end
    end
  end

endmodule

// File: doc/atomic_counter_reader.md
Name: atomic_counter_reader

Overview:
- Initiator side of the 32-bit req/ack counter-read interface: reads a 64-bit event counter as two single-copy-atomic 32-bit accesses.
- Access 1 carries the atomic flag and returns the low word; the responder latches the high word for access 2.
- Assembles the 64-bit snapshot and computes the delta (modulo 2^64) from the previous successful snapshot.
- Delivers both to a local consumer over a valid/ready handshake.
- Sits between the microcontroller-side command logic and the counter responder.

Parameters:
- ACK_TIMEOUT, 4: cycles to wait for ack_i after a request pulse before aborting (range 2..255).

Ports:
- clk  input  1  clock; all flops sample on the rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- start_i  input  1  request one 64-bit read; accepted only in IDLE
- req_o  output  1  request pulse to responder
- atomic_o  output  1  marks first (low-word) access; valid only with req_o
- ack_i  input  1  responder acknowledge, nominally one cycle after req_o
- count_i  input  32  responder data, sampled when ack_i=1
- value_o  output  64  assembled snapshot {hi,lo}
- delta_o  output  64  value_o minus previous successful snapshot, mod 2^64
- valid_o  output  1  value_o/delta_o valid
- ready_i  input  1  consumer accepts when valid_o&ready_i
- busy_o  output  1  1 in any state other than IDLE
- err_o  output  1  one-cycle pulse on ack timeout
- spurious_o  output  1  sticky; set by ack_i with no outstanding request; cleared only by reset

Behaviour:
- Reset (reset=0, async):
  - all outputs 0, state IDLE.
  - prev snapshot register 0; timeout counter 0.
  - value_o/delta_o low-word and high-word capture registers 0.
- FSM states: IDLE, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI, OUT.
- IDLE: start_i=1 -> REQ_LO. start_i is ignored in every other state (no queuing).
- REQ_LO (exactly one cycle):
  - req_o=1, atomic_o=1.
  - -> WAIT_LO; timeout counter loaded with 0.
- WAIT_LO:
  - ack_i=1 -> capture count_i into lo, -> REQ_HI.
  - otherwise increment the timeout counter. When it reaches ACK_TIMEOUT-1 with no ack, pulse err_o and go -> IDLE. No output update; the prev snapshot is unchanged.
- REQ_HI (exactly one cycle):
  - req_o=1, atomic_o=0.
  - -> WAIT_HI; timeout counter cleared.
- WAIT_HI:
  - ack_i=1 -> capture count_i as hi.
  - value_o <= {count_i, lo}; delta_o <= {count_i, lo} - prev; prev <= {count_i, lo}; valid_o <= 1; -> OUT.
  - Timeout rule is identical to WAIT_LO. On timeout the responder is left holding a stale high word, which is acceptable because the next read starts with atomic_o=1.
- OUT:
  - valid_o held 1 with value_o/delta_o stable until ready_i=1.
  - On acceptance: valid_o <= 0, -> IDLE. The next read can start the following cycle.
- Nominal latency, start_i to valid_o: 5 cycles, with ack arriving one cycle after each req pulse. Sequence: REQ_LO, WAIT_LO, REQ_HI, WAIT_HI, then valid_o registered.
- req_o is never high in two consecutive cycles; atomic_o=0 whenever req_o=0.
- ack_i sampled in IDLE, REQ_LO, REQ_HI or OUT sets spurious_o and is otherwise ignored.
- Delta arithmetic: plain 64-bit unsigned subtraction, wrapping. The first read after reset gives delta = value (prev=0).
- Reset mid-operation: returns to IDLE immediately. valid_o drops and any in-flight read is discarded. The responder may see an orphaned atomic request; this is harmless.
- busy_o is registered and equals (state != IDLE).

Test Plan:
1. Nominal read, responder preloaded 0x0000_0001_FFFF_FFFE, ack one cycle after each req:
   - Required: req_o pulses in cycles 1 and 3 after start_i, atomic_o=1 only on the first.
   - valid_o rises cycle 5 with value_o=0x0000_0001_FFFF_FFFE and delta_o=0x0000_0001_FFFF_FFFE.
2. Second read with counter advanced to 0x0000_0002_0000_0003 (low-word wrap between reads; responder returns the latched high word):
   - Required: value_o=0x0000_0002_0000_0003, delta_o=0x5.
3. Backpressure, ready_i held 0 for 6 cycles after valid_o:
   - valid_o and value_o stable throughout; start_i pulses during OUT are ignored (no req_o).
   - Exactly one transfer on ready_i=1.
4. Timeout, ACK_TIMEOUT=4, responder never acks the low access:
   - Required: err_o single-cycle pulse, return to IDLE, valid_o never asserts, prev unchanged.
   - A following good read of 0x10 gives delta_o=0x10-(last good value).
5. Spurious ack: ack_i=1 in IDLE -> spurious_o=1 and stays 1 through subsequent normal reads until reset; FSM unaffected.
6. Reset asserted during WAIT_HI:
   - Required: all outputs 0 asynchronously.
   - After release, a read of 0x0000_0000_0000_0007 gives delta_o=0x7.
